slave_spi_rx: RTL
=================

Name: slave_spi_rx

Overview:
- SPI slave receive block. It is the far end of the master_spi_tx link.
- It oversamples the master's SCK, MOSI and SPI enable in the system clock domain and shifts in MSB-first bytes on the mode-selected sampling edge.
- Each completed byte is presented on a valid/ready output port.
- It sits at the slave-side pins and feeds the slave's command/data logic.

Parameters:
CPOL, 1'b0, idle level of spi_clk_i (0 = idle low, 1 = idle high); must match the master.
CPHA, 1'b0, 0 = sample on the leading (first) SCK edge, 1 = sample on the trailing (second) SCK edge.

Ports:
clk_i  input  1  system clock; all logic is on its rising edge.
rst_i  input  1  synchronous reset, active-high.
spi_clk_i  input  1  SCK from the master; asynchronous to clk_i.
spi_rx_i  input  1  MOSI from the master; asynchronous.
spi_en_i  input  1  frame enable from master spi_en_o; active-high, asynchronous.
spi_rx_data_o  output  8  last received byte.
spi_rx_valid_o  output  1  spi_rx_data_o holds an unconsumed byte.
spi_rx_ready_i  input  1  consumer accepts the byte when valid and ready are both high.
spi_rx_ovr_o  output  1  1-cycle pulse: a new byte overwrote an unconsumed one.
spi_rx_err_o  output  1  1-cycle pulse: frame ended mid-byte.
spi_busy_o  output  1  high while a frame is active (state SHIFT).

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high (rst_i).
- Reset values:
  - data_o = 8'h00; valid, ovr, err, busy = 0.
  - Internal shift register = 0; bit_cnt = 0; state = IDLE.
  - Synchronizer flops are preset to sck = CPOL, mosi = 1, en = 0.
  - A reset mid-frame drops the partial byte and any pending valid. No err pulse is generated.
- Input synchronization:
  - spi_clk_i, spi_rx_i and spi_en_i each pass through a 2-FF synchronizer (s1 -> s2), followed by a delay flop s3.
  - Define sck_n = sck_s2 ^ CPOL. Rising sck_n is the leading edge; falling sck_n is the trailing edge.
  - sample_evt = the leading edge when CPHA=0, or the trailing edge when CPHA=1 (s2 vs s3 compare).
  - en_rise = en_s2 & ~en_s3. en_fall = ~en_s2 & en_s3.
- Timing constraint: the SCK high phase and low phase must each be at least 4 clk_i cycles. MOSI must be stable for at least 3 clk_i cycles around the sampling edge. The default master divider (SCK period of 500 clk_i cycles) satisfies both.
- FSM states: IDLE and SHIFT.
  - IDLE -> SHIFT on en_rise: bit_cnt <= 0, busy <= 1.
  - SHIFT, on sample_evt with en_s2 = 1: shift <= {shift[6:0], mosi_s2}; bit_cnt <= bit_cnt + 1.
  - When bit_cnt == 7 on that sample_evt (the 8th bit):
    - spi_rx_data_o <= {shift[6:0], mosi_s2};
    - valid <= 1;
    - bit_cnt wraps to 0 and the state stays SHIFT, so multiple bytes per frame are received back-to-back.
  - SHIFT -> IDLE on en_fall: busy <= 0.
    - If bit_cnt != 0, pulse err for 1 cycle and discard the partial byte.
    - If bit_cnt == 0, no err.
  - A sample_evt in a cycle where en_s2 = 0 is ignored.
  - sample_evt in IDLE is ignored.
- Latency: let k be the first clk_i rising edge after the 8th sampling SCK edge at the pin. valid and data update at clk edge k+2.
- Output handshake:
  - valid clears at the clock edge where valid & ready are both high.
  - If a byte completes in that same cycle, valid stays 1, new data loads, and there is no ovr.
  - If a byte completes while valid = 1 and ready = 0, data is overwritten, valid stays 1, and ovr pulses for 1 cycle.
- Simultaneous events: en_fall and en_rise cannot coincide. If en_fall and the 8th sample_evt coincide, en_s2 = 0, so the sample is ignored and an err pulse is generated.
- Polarity/phase coverage: the CPOL/CPHA decode must cover all 4 modes. MSB first is fixed.

Test Plan:
1. Mode 0, master sends 8'hA5, ready held 1 -> valid high for 1 cycle, data 8'hA5, at edge k+2 after the 8th SCK rise; err = 0, ovr = 0; busy falls 3 cycles after en falls.
2. Mode 0, one frame carrying 8'h3C then 8'hC3, ready = 1 -> two valid pulses, data 3C then C3; bit_cnt wraps, busy stays high between the bytes.
3. Mode 0, ready = 0, two bytes 8'h11 then 8'h22 -> valid stays high, data = 8'h22, one ovr pulse when the 2nd byte completes. Then ready = 1 for 1 cycle -> valid drops.
4. Master drops en after 5 bits -> err pulses exactly once, valid is not asserted. The next full frame 8'h5A is received correctly.
5. CPOL=1/CPHA=1 and CPOL=0/CPHA=1 with matching master, byte 8'h96 -> data 8'h96 in each mode; sampling occurs on the trailing edge.
6. rst_i asserted mid-frame after 4 bits, then released before a new frame 8'hFF -> outputs return to reset values, no err pulse, next byte 8'hFF received correctly.

Source files
------------

// File: rtl/slave_spi_rx.sv
// SPI slave receiver. It oversamples SCK, MOSI and the frame enable in the
// clk_i domain, shifts in MSB-first bytes on the mode-selected SCK edge, and
// presents each completed byte on a valid/ready port.
module slave_spi_rx #(
  parameter logic CPOL = 1'b0,
  parameter logic CPHA = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       spi_clk_i,
  input  logic       spi_rx_i,
  input  logic       spi_en_i,
  output logic [7:0] spi_rx_data_o,
  output logic       spi_rx_valid_o,
  input  logic       spi_rx_ready_i,
  output logic       spi_rx_ovr_o,
  output logic       spi_rx_err_o,
  output logic       spi_busy_o
);

  typedef enum logic {IDLE, SHIFT} state_e;

  // Synchronizer chains: bit 0 = s1, bit 1 = s2, bit 2 = s3 (edge-detect delay).
  logic [2:0] sck_q, mosi_q, en_q;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       ovr_q, ovr_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;

  logic sck_n2, sck_n3, lead_edge, trail_edge, sample_evt;
  logic en_rise, en_fall, mosi_s2;

  // Two-flop synchronizers plus one delay flop per asynchronous input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_q  <= {3{CPOL}};
      mosi_q <= 3'b111;
      en_q   <= 3'b000;
    end else begin
      sck_q  <= {sck_q[1:0], spi_clk_i};
      mosi_q <= {mosi_q[1:0], spi_rx_i};
      en_q   <= {en_q[1:0], spi_en_i};
    end
  end

  // Normalising SCK by CPOL makes the leading edge always a rising edge of
  // sck_n, so all four modes share one edge decoder.
  always_comb begin
    sck_n2     = sck_q[1] ^ CPOL;
    sck_n3     = sck_q[2] ^ CPOL;
    lead_edge  = sck_n2 & ~sck_n3;
    trail_edge = ~sck_n2 & sck_n3;
    sample_evt = CPHA ? trail_edge : lead_edge;
    en_rise    = en_q[1] & ~en_q[2];
    en_fall    = ~en_q[1] & en_q[2];
    mosi_s2    = mosi_q[1];
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state: frame tracking, bit shifting and the output handshake.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    // A consumer accept clears valid unless a new byte lands the same cycle.
    valid_d   = valid_q & ~spi_rx_ready_i;
    ovr_d     = 1'b0;
    err_d     = 1'b0;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        if (en_rise) begin
          state_d   = SHIFT;
          bit_cnt_d = 3'd0;
          shift_d   = 8'h00;
          busy_d    = 1'b1;
        end
      end
      SHIFT: begin
        if (en_fall) begin
          // en_s2 is already low here, so a coinciding sample is dropped.
          state_d   = IDLE;
          busy_d    = 1'b0;
          err_d     = (bit_cnt_q != 3'd0);
          bit_cnt_d = 3'd0;
          shift_d   = 8'h00;
        end else if (sample_evt && en_q[1]) begin
          shift_d   = {shift_q[6:0], mosi_s2};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            data_d  = {shift_q[6:0], mosi_s2};
            valid_d = 1'b1;
            ovr_d   = valid_q & ~spi_rx_ready_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign spi_rx_data_o  = data_q;
  assign spi_rx_valid_o = valid_q;
  assign spi_rx_ovr_o   = ovr_q;
  assign spi_rx_err_o   = err_q;
  assign spi_busy_o     = busy_q;

endmodule
